// File: rtl/cpu_pkg.sv
// Shared types and constants for the Thumb fetch-stage program-counter logic.
package cpu_pkg;

    typedef enum logic {
        IDLE,
        MULTI
    } seq_state_e;

    localparam int unsigned THUMB_STEP = 2;
    localparam int unsigned WIDE_STEP  = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/reg_list_walker.sv
// Register-list walker for multi-register transfers: keeps the not-yet-transferred
// registers and reports the lowest pending index and whether it is the final one.
module reg_list_walker #(
    parameter int unsigned LIST_W = 10,
    parameter int unsigned IDX_W  = $clog2(LIST_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic              clear,
    input  logic [LIST_W-1:0] load_list,
    output logic [IDX_W-1:0]  index,
    output logic              last
);

    logic [LIST_W-1:0] remaining;
    logic [LIST_W-1:0] lowest_cleared;
    logic              found;

    assign lowest_cleared = remaining & (remaining - LIST_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_list;
        end else if (advance) begin
            remaining <= lowest_cleared;
        end
    end

    // Lowest set bit wins; an empty list reports index 0.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < LIST_W; i++) begin
            if (remaining[i] && !found) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign last = (remaining != '0) && (lowest_cleared == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter for the Thumb fetch stage: selects the next PC from
// reset, branch, stall hold, multi-register transfer hold, or sequential step.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        LIST_W   = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned        IDX_W    = $clog2(LIST_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              wide_insn,
    input  logic              multi_start,
    input  logic [LIST_W-1:0] reg_list,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              multi_busy,
    output logic              multi_valid,
    output logic [IDX_W-1:0]  multi_index,
    output logic              multi_last
);

    seq_state_e        state;
    seq_state_e        next_state;
    logic              walk_load;
    logic              walk_advance;
    logic              walk_clear;
    logic [ADDR_W-1:0] target_aligned;
    logic [ADDR_W-1:0] pc_thumb;
    logic [ADDR_W-1:0] pc_seq;

    assign target_aligned = branch_target & ~ADDR_W'(1);
    assign pc_thumb       = pc + ADDR_W'(THUMB_STEP);
    assign pc_seq         = pc + (wide_insn ? ADDR_W'(WIDE_STEP) : ADDR_W'(THUMB_STEP));

    reg_list_walker #(
        .LIST_W (LIST_W),
        .IDX_W  (IDX_W)
    ) u_walker (
        .clk       (clk),
        .reset     (reset),
        .load      (walk_load),
        .advance   (walk_advance),
        .clear     (walk_clear),
        .load_list (reg_list),
        .index     (multi_index),
        .last      (multi_last)
    );

    always_comb begin
        next_pc      = pc;
        next_state   = state;
        walk_load    = 1'b0;
        walk_advance = 1'b0;
        walk_clear   = 1'b0;
        multi_valid  = 1'b0;
        if (reset) begin
            next_pc    = RESET_PC;
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (branch) begin
                        next_pc = target_aligned;
                    end else if (stall) begin
                        next_pc = pc;
                    end else if (multi_start && (reg_list != '0)) begin
                        walk_load  = 1'b1;
                        next_state = MULTI;
                    end else if (multi_start) begin
                        // An empty list behaves as a plain 16-bit instruction.
                        next_pc = pc_thumb;
                    end else begin
                        next_pc = pc_seq;
                    end
                end
                MULTI: begin
                    if (branch) begin
                        next_pc    = target_aligned;
                        walk_clear = 1'b1;
                        next_state = IDLE;
                    end else if (!stall) begin
                        multi_valid = 1'b1;
                        if (multi_last) begin
                            next_pc    = pc_thumb;
                            walk_clear = 1'b1;
                            next_state = IDLE;
                        end else begin
                            walk_advance = 1'b1;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            multi_busy <= 1'b0;
            pc         <= RESET_PC;
        end else begin
            state      <= next_state;
            multi_busy <= (next_state == MULTI);
            pc         <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch-stage PC behaviour.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LIST_W = 10;
    localparam int unsigned IDX_W  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              branch;
    logic [ADDR_W-1:0] branch_target;
    logic              wide_insn;
    logic              multi_start;
    logic [LIST_W-1:0] reg_list;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              multi_busy;
    logic              multi_valid;
    logic [IDX_W-1:0]  multi_index;
    logic              multi_last;

    int checks   = 0;
    int failures = 0;

    // Reference model state: PC, busy flag and the pending register indices.
    logic [31:0] m_pc;
    logic        m_busy;
    int          m_q[$];

    pc_sequencer #(
        .ADDR_W   (ADDR_W),
        .LIST_W   (LIST_W),
        .RESET_PC (RST_PC),
        .IDX_W    (IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .branch_target (branch_target),
        .wide_insn     (wide_insn),
        .multi_start   (multi_start),
        .reg_list      (reg_list),
        .pc            (pc),
        .next_pc       (next_pc),
        .multi_busy    (multi_busy),
        .multi_valid   (multi_valid),
        .multi_index   (multi_index),
        .multi_last    (multi_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_next();
        if (reset) return RST_PC;
        if (branch) return {branch_target[31:1], 1'b0};
        if (stall) return m_pc;
        if (!m_busy) begin
            if (multi_start && reg_list != 0) return m_pc;
            if (multi_start) return m_pc + 32'd2;
            return m_pc + (wide_insn ? 32'd4 : 32'd2);
        end
        if (m_q.size() == 1) return m_pc + 32'd2;
        return m_pc;
    endfunction

    function automatic logic exp_valid();
        return !reset && m_busy && !stall && !branch;
    endfunction

    function automatic logic [IDX_W-1:0] exp_index();
        if (m_q.size() == 0) return '0;
        return IDX_W'(m_q[0]);
    endfunction

    function automatic logic exp_last();
        return m_q.size() == 1;
    endfunction

    function automatic void model_advance();
        logic [31:0] npc;
        npc = exp_next();
        if (reset || branch) begin
            m_busy = 1'b0;
            m_q.delete();
        end else if (stall) begin
            // everything holds
        end else if (!m_busy) begin
            if (multi_start && reg_list != 0) begin
                for (int b = 0; b < int'(LIST_W); b++)
                    if (reg_list[b]) m_q.push_back(b);
                m_busy = 1'b1;
            end
        end else begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_busy = 1'b0;
        end
        m_pc = npc;
    endfunction

    task automatic go();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        reset = 0; stall = 0; branch = 0; branch_target = '0;
        wide_insn = 0; multi_start = 0; reg_list = '0;
    endtask

    task automatic jump(input logic [31:0] t);
        quiet(); branch = 1; branch_target = t;
        go();
        branch = 0;
    endtask

    task automatic test_reset();
        quiet(); reset = 1;
        m_pc = 32'hDEAD_BEEF; m_busy = 1'b0; m_q.delete();
        go(); go();
        #1;
        checks++; if (next_pc !== RST_PC) begin failures++; $display("FAIL reset_next_pc got=%h exp=%h", next_pc, RST_PC); end
        checks++; if (pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
        checks++; if ({multi_busy, multi_valid, multi_last} !== 3'b000 || multi_index !== '0) begin
            failures++; $display("FAIL reset_outputs got=%b%b%b idx=%0d exp=000 idx=0", multi_busy, multi_valid, multi_last, multi_index); end
        reset = 0;
    endtask

    task automatic test_sequential();
        quiet();
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++; if (next_pc !== 32'(2 * i)) begin failures++; $display("FAIL seq_next_pc got=%h exp=%h", next_pc, 32'(2 * i)); end
            go();
            checks++; if (pc !== 32'(2 * i)) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'(2 * i)); end
        end
        wide_insn = 1;
        go();
        checks++; if (pc !== 32'd10) begin failures++; $display("FAIL seq_wide_pc got=%h exp=%h", pc, 32'd10); end
    endtask

    task automatic test_multi();
        int exp_idx[3] = '{0, 3, 5};
        jump(32'h100);
        multi_start = 1; reg_list = 10'b00_0010_1001;
        #1;
        checks++; if (multi_valid !== 1'b0 || next_pc !== 32'h100) begin failures++; $display("FAIL multi_start_cycle valid=%b next=%h exp valid=0 next=100", multi_valid, next_pc); end
        go();
        multi_start = 1; reg_list = 10'h3FF;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (multi_busy !== 1'b1 || multi_valid !== 1'b1) begin failures++; $display("FAIL multi_xfer_valid k=%0d busy=%b valid=%b exp 1 1", k, multi_busy, multi_valid); end
            checks++; if (multi_index !== IDX_W'(exp_idx[k])) begin failures++; $display("FAIL multi_index k=%0d got=%0d exp=%0d", k, multi_index, exp_idx[k]); end
            checks++; if (multi_last !== (k == 2)) begin failures++; $display("FAIL multi_last k=%0d got=%b exp=%b", k, multi_last, k == 2); end
            checks++; if (pc !== 32'h100) begin failures++; $display("FAIL multi_pc_hold k=%0d got=%h exp=100", k, pc); end
            go();
        end
        quiet();
        checks++; if (pc !== 32'h102 || multi_busy !== 1'b0) begin failures++; $display("FAIL multi_done pc=%h busy=%b exp pc=102 busy=0", pc, multi_busy); end
        #1;
        checks++; if (multi_valid !== 1'b0) begin failures++; $display("FAIL multi_after_valid got=%b exp=0", multi_valid); end
    endtask

    task automatic test_multi_stall();
        logic stall_pat[6] = '{0, 1, 1, 0, 0, 0};
        logic vld_pat[6]   = '{1, 0, 0, 1, 1, 0};
        int   idx_pat[6]   = '{0, 3, 3, 3, 5, 0};
        int   pulses = 0;
        jump(32'h100);
        multi_start = 1; reg_list = 10'b00_0010_1001;
        go();
        quiet();
        for (int c = 0; c < 6; c++) begin
            stall = stall_pat[c];
            #1;
            if (multi_valid === 1'b1) pulses++;
            checks++; if (multi_valid !== vld_pat[c] || multi_index !== IDX_W'(idx_pat[c])) begin
                failures++; $display("FAIL stall_xfer c=%0d valid=%b idx=%0d exp valid=%b idx=%0d", c, multi_valid, multi_index, vld_pat[c], idx_pat[c]); end
            go();
        end
        checks++; if (pulses != 3 || pc !== 32'h104) begin failures++; $display("FAIL stall_total pulses=%0d pc=%h exp pulses=3 pc=104", pulses, pc); end
    endtask

    task automatic test_branch_abort();
        int pulses = 0;
        jump(32'h100);
        multi_start = 1; reg_list = 10'h00F;
        go();
        quiet();
        #1;
        if (multi_valid === 1'b1) pulses++;
        go();
        branch = 1; branch_target = 32'h201;
        #1;
        checks++; if (multi_valid !== 1'b0 || next_pc !== 32'h200) begin failures++; $display("FAIL abort_cycle valid=%b next=%h exp valid=0 next=200", multi_valid, next_pc); end
        go();
        quiet();
        #1;
        checks++; if (pc !== 32'h200 || multi_busy !== 1'b0 || multi_valid !== 1'b0) begin
            failures++; $display("FAIL abort_after pc=%h busy=%b valid=%b exp pc=200 busy=0 valid=0", pc, multi_busy, multi_valid); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL abort_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_zero_list();
        jump(32'h40);
        multi_start = 1; reg_list = '0; wide_insn = 1;
        go();
        checks++; if (pc !== 32'h42 || multi_busy !== 1'b0) begin failures++; $display("FAIL zero_list pc=%h busy=%b exp pc=42 busy=0", pc, multi_busy); end
        quiet();
        branch = 1; branch_target = 32'h81; multi_start = 1; reg_list = 10'h003;
        go();
        quiet();
        #1;
        checks++; if (pc !== 32'h80 || multi_busy !== 1'b0 || multi_valid !== 1'b0) begin
            failures++; $display("FAIL branch_drops_multi pc=%h busy=%b valid=%b exp pc=80 busy=0 valid=0", pc, multi_busy, multi_valid); end
    endtask

    task automatic test_wrap();
        jump(32'hFFFF_FFFF);
        checks++; if (pc !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_setup got=%h exp=fffffffe", pc); end
        go();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_thumb got=%h exp=0", pc); end
        jump(32'hFFFF_FFFE);
        wide_insn = 1;
        go();
        checks++; if (pc !== 32'h2) begin failures++; $display("FAIL wrap_wide got=%h exp=2", pc); end
    endtask

    task automatic test_reset_mid_multi();
        jump(32'h300);
        multi_start = 1; reg_list = 10'h3FF;
        go();
        quiet();
        go();
        reset = 1;
        #1;
        checks++; if (multi_valid !== 1'b0 || next_pc !== RST_PC) begin failures++; $display("FAIL rst_mid_cycle valid=%b next=%h exp valid=0 next=%h", multi_valid, next_pc, RST_PC); end
        go();
        reset = 0;
        #1;
        checks++; if (pc !== RST_PC || {multi_busy, multi_valid, multi_last} !== 3'b000 || multi_index !== '0) begin
            failures++; $display("FAIL rst_mid_after pc=%h bvl=%b%b%b idx=%0d exp pc=%h bvl=000 idx=0", pc, multi_busy, multi_valid, multi_last, multi_index, RST_PC); end
        go();
        checks++; if (multi_busy !== 1'b0 || pc !== RST_PC + 32'd2) begin failures++; $display("FAIL rst_mid_resume pc=%h busy=%b exp pc=%h busy=0", pc, multi_busy, RST_PC + 32'd2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            branch        = ($urandom_range(0, 15) == 0);
            branch_target = $urandom;
            wide_insn     = $urandom_range(0, 1) == 1;
            multi_start   = ($urandom_range(0, 3) == 0);
            reg_list      = ($urandom_range(0, 5) == 0) ? '0 : LIST_W'($urandom);
            #1;
            checks++; if (next_pc !== exp_next()) begin failures++; $display("FAIL rnd_next_pc n=%0d got=%h exp=%h", n, next_pc, exp_next()); end
            checks++; if (multi_valid !== exp_valid() || multi_index !== exp_index() || multi_last !== exp_last()) begin
                failures++; $display("FAIL rnd_walker n=%0d v/i/l=%b/%0d/%b exp=%b/%0d/%b", n, multi_valid, multi_index, multi_last, exp_valid(), exp_index(), exp_last()); end
            go();
            checks++; if (pc !== m_pc || multi_busy !== m_busy) begin failures++; $display("FAIL rnd_state n=%0d pc=%h busy=%b exp pc=%h busy=%b", n, pc, multi_busy, m_pc, m_busy); end
        end
    endtask

    initial begin
        quiet();
        reset = 1;
        #1;
        test_reset();
        test_sequential();
        test_multi();
        test_multi_stall();
        test_branch_abort();
        test_zero_list();
        test_wrap();
        test_reset_mid_multi();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the Thumb fetch stage. Holds PC and selects the next PC from reset vector, branch target, stall hold, multi-register transfer hold, or sequential increment.
- Generalises the combinational next-PC selector:
  - parametrised address and register-list widths;
  - internal register-list walker replaces the external list counter;
  - 16/32-bit instruction stepping;
  - explicit pipeline stall input.
- Sits between the branch unit / decoder and the instruction-memory address port.

Parameters:
- ADDR_W, 32: PC width in bits.
- LIST_W, 10: register-list width for LDM/STM/PUSH/POP; one bit per register.
- RESET_PC, 32'h0000_0000: PC value loaded by reset.
- IDX_W, $clog2(LIST_W): width of the register index output.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freezes PC and walker state this cycle.
- branch  in  1  take branch this cycle; highest priority after reset.
- branch_target  in  ADDR_W  branch destination; bit 0 ignored (Thumb bit).
- wide_insn  in  1  current instruction is 32-bit (BL); sequential step is 4 instead of 2.
- multi_start  in  1  decoder presents a multi-register transfer; sampled only in IDLE.
- reg_list  in  LIST_W  register list accompanying multi_start.
- pc  out  ADDR_W  registered current PC.
- next_pc  out  ADDR_W  combinational value pc takes on the next edge; drives the fetch address.
- multi_busy  out  1  registered; high while in MULTI.
- multi_valid  out  1  combinational; one transfer is issued this cycle (MULTI and not stall).
- multi_index  out  IDX_W  index of the lowest set bit of the remaining list.
- multi_last  out  1  remaining list has exactly one bit set.

Behaviour:
- Reset (synchronous, priority over everything):
  - pc=RESET_PC, state=IDLE, remaining=0;
  - multi_busy=0, multi_valid=0, multi_index=0, multi_last=0.
  - Reset asserted mid-MULTI abandons the transfer, with no further multi_valid.
- States: IDLE, MULTI.
- IDLE priority (first match wins):
  1. branch: pc<=branch_target with bit0 cleared; stay IDLE. A simultaneous multi_start is dropped.
  2. stall: pc holds.
  3. multi_start with reg_list!=0: remaining<=reg_list, pc holds, go MULTI.
  4. multi_start with reg_list==0: treated as an ordinary instruction; pc<=pc+2.
  5. otherwise: pc<=pc+(wide_insn ? 4 : 2).
- MULTI priority:
  1. branch: pc<=target with bit0 cleared, remaining<=0, go IDLE. Abort; no multi_valid that cycle.
  2. stall: pc, remaining and state all hold; multi_valid=0; multi_index/multi_last remain stable.
  3. multi_last=1: pc<=pc+2, remaining<=0, go IDLE. This cycle is the final transfer.
  4. otherwise: remaining<=remaining with its lowest set bit cleared; pc holds.
  - multi_start is ignored while in MULTI.
- Walker:
  - multi_index is a priority encode of remaining, lowest index first.
  - Transfer count equals popcount(reg_list); exactly one multi_valid pulse per set bit.
  - pc stays constant from the multi_start cycle until the last transfer.
- Arithmetic: all adds modulo 2^ADDR_W. 32'hFFFF_FFFE+2 wraps to 0 with no flag.
- next_pc: always equals the value pc will hold after the next edge; equals RESET_PC while reset=1.
- Latency: pc updates one cycle after the selecting inputs; next_pc has zero latency.

Decomposition:
- Shared package cpu_pkg:
  - state enum (IDLE, MULTI);
  - THUMB_STEP=2, WIDE_STEP=4;
  - default RESET_PC.
- One natural sub-module: reg_list_walker. Holds the remaining register, priority encoder, lowest-bit clear, and last-bit detect, with load/advance/clear inputs.
- PC register and next-PC mux stay in the top level.

Test Plan:
- Reset then 3 free cycles, wide_insn=0 -> pc 0,2,4,6; then one cycle wide_insn=1 -> pc 10.
- At pc=0x100, multi_start with reg_list=10'b00_0010_1001 -> multi_valid on 3 cycles with index 0,3,5; multi_last on the third; pc holds 0x100 throughout, then becomes 0x102.
- Same list with stall asserted during the second transfer for 2 cycles -> index 3 held, no multi_valid during stall, 3 transfers total, final pc 0x102.
- Branch to 0x201 during second transfer of reg_list=10'h00F -> pc=0x200 next cycle, multi_busy=0, exactly 1 prior multi_valid.
- multi_start with reg_list=0 at pc=0x40 -> pc=0x42, multi_busy stays 0; branch+multi_start together in IDLE -> branch taken, no MULTI.
- pc=0xFFFF_FFFE with a sequential step -> pc=0; reset asserted mid-MULTI -> pc=RESET_PC and all outputs 0 next cycle.
